// File: rtl/sram_controller.sv
// Splits 32-bit MEM-stage loads/stores into low/high halfword phases on a
// 16-bit asynchronous SRAM, holding ready low while an access is in flight.
module sram_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_W_EN,
  input  logic               MEM_R_EN,
  input  logic [31:0]        address,
  input  logic [31:0]        storeValue,
  output logic [31:0]        memoryData,
  output logic               ready,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [15:0]        SRAM_WDATA,
  input  logic [15:0]        SRAM_RDATA,
  output logic               SRAM_DQ_OE,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  logic [1:0]         state;
  logic [3:0]         cnt;
  logic [SRAM_AW-2:0] word_q;
  logic [31:0]        data_q;
  logic               write_q;
  logic [15:0]        low_q;

  logic        req;
  logic        last;
  logic [31:0] internal;
  logic        unused_internal;

  assign req      = MEM_W_EN | MEM_R_EN;
  assign last     = (cnt == 4'd0);
  assign internal = address - 32'(BASE_ADDR);
  // Byte offset and bits above the SRAM range are dropped: word-aligned, wrapping.
  assign unused_internal = &{1'b0, internal[31:SRAM_AW+1], internal[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      word_q     <= '0;
      data_q     <= 32'd0;
      write_q    <= 1'b0;
      low_q      <= 16'd0;
      memoryData <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            word_q  <= internal[SRAM_AW:2];
            data_q  <= storeValue;
            write_q <= MEM_W_EN;
            cnt     <= CNT_INIT;
            state   <= LOW;
          end
        end
        LOW: begin
          if (last) begin
            if (!write_q) low_q <= SRAM_RDATA;
            cnt   <= CNT_INIT;
            state <= HIGH;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HIGH: begin
          if (last) begin
            // High half comes straight from the pad on the final phase cycle.
            if (!write_q) memoryData <= {SRAM_RDATA, low_q};
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ready      = 1'b1;
    SRAM_ADDR  = '0;
    SRAM_WDATA = 16'd0;
    SRAM_DQ_OE = 1'b0;
    SRAM_WE_N  = 1'b1;
    SRAM_OE_N  = 1'b1;
    case (state)
      IDLE: ready = ~req;
      LOW: begin
        ready     = 1'b0;
        SRAM_ADDR = {word_q, 1'b0};
        if (write_q) begin
          SRAM_WDATA = data_q[15:0];
          SRAM_DQ_OE = 1'b1;
          SRAM_WE_N  = 1'b0;
        end else begin
          SRAM_OE_N = 1'b0;
        end
      end
      HIGH: begin
        ready     = 1'b0;
        SRAM_ADDR = {word_q, 1'b1};
        if (write_q) begin
          SRAM_WDATA = data_q[31:16];
          SRAM_DQ_OE = 1'b1;
          SRAM_WE_N  = 1'b0;
        end else begin
          SRAM_OE_N = 1'b0;
        end
      end
      default: ready = 1'b1;
    endcase
  end

endmodule
